// File: rtl/hsm_axil_pkg.sv
// Shared types and helpers for the HSM AXI4-Lite register file.
package hsm_axil_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } axi_resp_e;

    localparam int REG_BYTES = 4;

    function automatic int idx_width(input int n);
        return $clog2(n);
    endfunction

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                 input logic [31:0] new_val,
                                                 input logic [3:0]  strb);
        logic [31:0] result;
        result = old_val;
        for (int b = 0; b < REG_BYTES; b++) begin
            if (strb[b]) result[8*b +: 8] = new_val[8*b +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/hsm_axil_hold.sv
// One-entry valid/ready holding register; ready is registered so it stays low
// through reset and rises on the first clock edge after release.
module hsm_axil_hold #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             clear,
    output logic             ready,
    output logic             full,
    output logic [WIDTH-1:0] data
);

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready <= 1'b0;
            full  <= 1'b0;
            data  <= '0;
        end else if (in_valid && ready) begin
            ready <= 1'b0;
            full  <= 1'b1;
            data  <= in_data;
        end else if (clear) begin
            ready <= 1'b1;
            full  <= 1'b0;
        end else begin
            ready <= !full;
        end
    end

endmodule

// File: rtl/hsm_axil_regfile.sv
// AXI4-Lite slave register file with per-register read-only mask, byte strobes,
// SLVERR on illegal accesses and per-register access pulses for attached cores.
module hsm_axil_regfile
    import hsm_axil_pkg::*;
#(
    parameter int                  C_S_AXI_DATA_WIDTH = 32,
    parameter int                  C_S_AXI_ADDR_WIDTH = 5,
    parameter int                  NUM_REGS           = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK            = 8'hF2
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [NUM_REGS*32-1:0]          reg_q,
    input  logic [NUM_REGS*32-1:0]          hw_rdata,
    output logic [NUM_REGS-1:0]             wr_pulse,
    output logic [NUM_REGS-1:0]             rd_pulse
);

    localparam int ADDR_W = C_S_AXI_ADDR_WIDTH;
    localparam int DATA_W = C_S_AXI_DATA_WIDTH;
    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = ADDR_W - 2;

    logic                     aw_full;
    logic                     w_full;
    logic [ADDR_W-1:0]        aw_addr;
    logic [DATA_W+STRB_W-1:0] w_buf;
    logic [DATA_W-1:0]        w_data;
    logic [STRB_W-1:0]        w_strb;
    logic                     commit;
    logic [IDX_W-1:0]         w_idx;
    logic [IDX_W-1:0]         r_idx;
    logic [NUM_REGS-1:0]      w_hit;
    logic [NUM_REGS-1:0]      r_hit;
    logic                     w_ok;
    logic                     r_ok;
    logic [31:0]              rd_val;
    logic                     ar_hs;
    axi_resp_e                bresp_q;
    axi_resp_e                rresp_q;

    hsm_axil_hold #(.WIDTH(ADDR_W)) u_aw_hold (
        .clk      (S_AXI_ACLK),
        .rst_n    (S_AXI_ARESETN),
        .in_valid (S_AXI_AWVALID),
        .in_data  (S_AXI_AWADDR),
        .clear    (commit),
        .ready    (S_AXI_AWREADY),
        .full     (aw_full),
        .data     (aw_addr)
    );

    hsm_axil_hold #(.WIDTH(DATA_W + STRB_W)) u_w_hold (
        .clk      (S_AXI_ACLK),
        .rst_n    (S_AXI_ARESETN),
        .in_valid (S_AXI_WVALID),
        .in_data  ({S_AXI_WDATA, S_AXI_WSTRB}),
        .clear    (commit),
        .ready    (S_AXI_WREADY),
        .full     (w_full),
        .data     (w_buf)
    );

    assign w_data = w_buf[DATA_W+STRB_W-1:STRB_W];
    assign w_strb = w_buf[STRB_W-1:0];
    assign w_idx  = aw_addr[ADDR_W-1:2];
    assign r_idx  = S_AXI_ARADDR[ADDR_W-1:2];
    assign commit = aw_full && w_full && (!S_AXI_BVALID || S_AXI_BREADY);
    assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;

    // PROT and the byte-lane address bits carry no meaning for word registers.
    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, aw_addr[1:0], S_AXI_ARADDR[1:0]};

    // Out-of-range and read-only indices simply never produce a write hit.
    always_comb begin
        // NOTE: defaults first so no path through the block leaves a variable unassigned (no latch).
        w_hit  = '0;
        r_hit  = '0;
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(w_idx) == i && !RO_MASK[i]) w_hit[i] = 1'b1;
            if (int'(r_idx) == i) begin
                r_hit[i] = 1'b1;
                rd_val   = RO_MASK[i] ? hw_rdata[i*32 +: 32] : reg_q[i*32 +: 32];
            end
        end
    end

    assign w_ok = |w_hit;
    assign r_ok = |r_hit;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        if (RO_MASK[g]) begin : g_ro
            assign reg_q[g*32 +: 32] = '0;
        end else begin : g_rw
            logic [31:0] value;
            // NOTE: these are discrete flops, not a RAM, so resetting them costs nothing and keeps reg_q defined.
            always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
                if (!S_AXI_ARESETN) begin
                    value <= '0;
                end else if (commit && w_hit[g]) begin
                    value <= apply_wstrb(value, w_data, w_strb);
                end
            end
            assign reg_q[g*32 +: 32] = value;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            S_AXI_BVALID <= 1'b0;
            bresp_q      <= RESP_OKAY;
            wr_pulse     <= '0;
        end else begin
            wr_pulse <= '0;
            if (commit) begin
                S_AXI_BVALID <= 1'b1;
                bresp_q      <= w_ok ? RESP_OKAY : RESP_SLVERR;
                wr_pulse     <= w_hit;
            end else if (S_AXI_BREADY) begin
                S_AXI_BVALID <= 1'b0;
            end
        end
    end

    // ARREADY mirrors !RVALID but is registered so it stays low through reset.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            rresp_q       <= RESP_OKAY;
            rd_pulse      <= '0;
        end else begin
            rd_pulse <= '0;
            if (ar_hs) begin
                S_AXI_ARREADY <= 1'b0;
                S_AXI_RVALID  <= 1'b1;
                S_AXI_RDATA   <= r_ok ? rd_val : '0;
                rresp_q       <= r_ok ? RESP_OKAY : RESP_SLVERR;
                rd_pulse      <= r_hit;
            end else if (S_AXI_RVALID && S_AXI_RREADY) begin
                S_AXI_ARREADY <= 1'b1;
                S_AXI_RVALID  <= 1'b0;
            end else begin
                S_AXI_ARREADY <= !S_AXI_RVALID;
            end
        end
    end

    assign S_AXI_BRESP = bresp_q;
    assign S_AXI_RRESP = rresp_q;

endmodule

// File: tb/tb_hsm_axil_regfile.sv
// Directed bench for hsm_axil_regfile: a vector table of single accesses plus
// hand-written sequences for ordering, back-pressure, reset and range corners.
module tb_hsm_axil_regfile;

    logic         clk;
    logic         rst_n;
    logic [4:0]   awaddr, araddr;
    logic [2:0]   awprot, arprot;
    logic         awvalid, wvalid, bready, arvalid, rready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         awready, wready, bvalid, arready, rvalid;
    logic [1:0]   bresp, rresp;
    logic [31:0]  rdata;
    logic [255:0] reg_q, hw_rdata;
    logic [7:0]   wr_pulse, rd_pulse;

    // Second instance: six registers, so the upper addresses are out of range.
    logic [4:0]   s_awaddr, s_araddr;
    logic         s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
    logic [31:0]  s_wdata;
    logic         s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [1:0]   s_bresp, s_rresp;
    logic [31:0]  s_rdata;
    logic [191:0] s_reg_q, s_hw_rdata;
    logic [5:0]   s_wr_pulse, s_rd_pulse;

    int checks = 0;
    int errors = 0;

    hsm_axil_regfile dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .reg_q(reg_q), .hw_rdata(hw_rdata), .wr_pulse(wr_pulse), .rd_pulse(rd_pulse)
    );

    hsm_axil_regfile #(.NUM_REGS(6), .RO_MASK(6'h02)) dut6 (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(s_awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(s_awvalid), .S_AXI_AWREADY(s_awready),
        .S_AXI_WDATA(s_wdata), .S_AXI_WSTRB(4'hF), .S_AXI_WVALID(s_wvalid), .S_AXI_WREADY(s_wready),
        .S_AXI_BRESP(s_bresp), .S_AXI_BVALID(s_bvalid), .S_AXI_BREADY(s_bready),
        .S_AXI_ARADDR(s_araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(s_arvalid), .S_AXI_ARREADY(s_arready),
        .S_AXI_RDATA(s_rdata), .S_AXI_RRESP(s_rresp), .S_AXI_RVALID(s_rvalid), .S_AXI_RREADY(s_rready),
        .reg_q(s_reg_q), .hw_rdata(s_hw_rdata), .wr_pulse(s_wr_pulse), .rd_pulse(s_rd_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Simultaneous AW+W; lat counts edges from the last handshake edge to BVALID.
    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output int lat,
                             output logic [7:0] pulse, output logic [7:0] pulse_after);
        logic aw_done, w_done;
        int   n;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        aw_done = 1'b0; w_done = 1'b0; n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            if (awvalid && awready) aw_done = 1'b1;
            if (wvalid && wready) w_done = 1'b1;
            tick();
            if (aw_done) awvalid = 1'b0;
            if (w_done) wvalid = 1'b0;
            n++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        lat = 0;
        while (!bvalid && lat < 20) begin
            tick();
            lat++;
        end
        if (n >= 20) lat = 99;
        resp  = bresp;
        pulse = wr_pulse;
        tick();
        pulse_after = wr_pulse;
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp,
                            output logic [7:0] pulse, output logic ar_low, output logic ar_back,
                            output logic [7:0] pulse_after);
        int n;
        @(negedge clk);
        araddr = a; arvalid = 1'b1; rready = 1'b1; n = 0;
        while (!arready && n < 20) begin
            tick();
            n++;
        end
        tick();
        arvalid = 1'b0;
        d      = rdata;
        resp   = rresp;
        pulse  = rd_pulse;
        ar_low = !arready && rvalid;
        tick();
        ar_back     = arready && !rvalid;
        pulse_after = rd_pulse;
    endtask

    typedef struct {
        logic        is_wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] value;
        logic [7:0]  pulse;
    } vec_t;

    vec_t vecs[14];

    initial begin
        logic [1:0]  resp;
        logic [31:0] d;
        logic [7:0]  pulse, pulse_after;
        logic        ar_low, ar_back;
        int          lat;
        int          idx;

        rst_n = 1'b1;
        awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1; arvalid = 1'b0; rready = 1'b1;
        wdata = '0; wstrb = '0;
        s_awaddr = '0; s_araddr = '0; s_awvalid = 1'b0; s_wvalid = 1'b0;
        s_bready = 1'b1; s_arvalid = 1'b0; s_rready = 1'b1; s_wdata = '0;
        for (int i = 0; i < 8; i++) hw_rdata[i*32 +: 32] = 32'hDEAD_0000 | i;
        for (int i = 0; i < 6; i++) s_hw_rdata[i*32 +: 32] = 32'hBAD0_0000 | i;

        // Kinds: W = write (value is the slot's reg_q after commit), R = read (value is RDATA).
        vecs[0]  = '{1'b1, 5'h00, 32'hA5A5_0001, 4'hF, 2'b00, 32'hA5A5_0001, 8'h01};
        vecs[1]  = '{1'b1, 5'h0C, 32'hFFFF_FFFF, 4'hF, 2'b00, 32'hFFFF_FFFF, 8'h08};
        vecs[2]  = '{1'b1, 5'h0C, 32'h0000_0000, 4'h3, 2'b00, 32'hFFFF_0000, 8'h08};
        vecs[3]  = '{1'b1, 5'h0C, 32'h1234_5678, 4'h0, 2'b00, 32'hFFFF_0000, 8'h08};
        vecs[4]  = '{1'b1, 5'h04, 32'h1111_1111, 4'hF, 2'b10, 32'h0000_0000, 8'h00};
        vecs[5]  = '{1'b1, 5'h1F, 32'h2222_2222, 4'hF, 2'b10, 32'h0000_0000, 8'h00};
        vecs[6]  = '{1'b0, 5'h08, 32'h0,         4'h0, 2'b00, 32'h0000_0000, 8'h04};
        vecs[7]  = '{1'b1, 5'h08, 32'hFFFF_FFFF, 4'hF, 2'b00, 32'hFFFF_FFFF, 8'h04};
        vecs[8]  = '{1'b0, 5'h00, 32'h0,         4'h0, 2'b00, 32'hA5A5_0001, 8'h01};
        vecs[9]  = '{1'b0, 5'h18, 32'h0,         4'h0, 2'b00, 32'hDEAD_0006, 8'h40};
        vecs[10] = '{1'b0, 5'h0E, 32'h0,         4'h0, 2'b00, 32'hFFFF_0000, 8'h08};
        vecs[11] = '{1'b0, 5'h10, 32'h0,         4'h0, 2'b00, 32'hDEAD_0004, 8'h10};
        vecs[12] = '{1'b1, 5'h0A, 32'h00AB_00CD, 4'hA, 2'b00, 32'h00FF_00FF, 8'h04};
        vecs[13] = '{1'b1, 5'h08, 32'hFFFF_FFFF, 4'hF, 2'b00, 32'hFFFF_FFFF, 8'h04};

        // Reset state, asserted without a clock edge.
        #1 rst_n = 1'b0;
        #2;
        check("rst_ready_valid", {awready, wready, arready, bvalid, rvalid}, 5'b0);
        check("rst_data", {bresp, rresp, rdata}, '0);
        check("rst_reg_q", reg_q[63:0], '0);
        check("rst_pulses", {wr_pulse, rd_pulse}, '0);
        tick();
        tick();
        rst_n = 1'b1;
        #1 check("rel_ready_low", {awready, wready, arready}, 3'b000);
        @(negedge clk);
        check("rel_ready_high", {awready, wready, arready}, 3'b111);

        for (int i = 0; i < 14; i++) begin
            idx = int'(vecs[i].addr[4:2]);
            if (vecs[i].is_wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, lat, pulse, pulse_after);
                check($sformatf("v%0d_bresp", i), resp, vecs[i].resp);
                check($sformatf("v%0d_latency", i), lat, 1);
                check($sformatf("v%0d_reg_q", i), reg_q[idx*32 +: 32], vecs[i].value);
                check($sformatf("v%0d_wr_pulse", i), pulse, vecs[i].pulse);
                check($sformatf("v%0d_wr_pulse_after", i), pulse_after, 8'h00);
            end else begin
                axi_read(vecs[i].addr, d, resp, pulse, ar_low, ar_back, pulse_after);
                check($sformatf("v%0d_rdata", i), d, vecs[i].value);
                check($sformatf("v%0d_rresp", i), resp, vecs[i].resp);
                check($sformatf("v%0d_rd_pulse", i), pulse, vecs[i].pulse);
                check($sformatf("v%0d_arready_low", i), ar_low, 1'b1);
                check($sformatf("v%0d_arready_back", i), ar_back, 1'b1);
                check($sformatf("v%0d_rd_pulse_after", i), pulse_after, 8'h00);
            end
        end

        // W three edges before AW: commit lands on the edge after the AW handshake.
        @(negedge clk);
        wdata = 32'h1122_3344; wstrb = 4'b0101; wvalid = 1'b1; bready = 1'b1;
        tick();
        wvalid = 1'b0;
        check("wfirst_wready_low", wready, 1'b0);
        tick();
        check("wfirst_no_bvalid", bvalid, 1'b0);
        tick();
        awaddr = 5'h08; awvalid = 1'b1;
        check("wfirst_awready", awready, 1'b1);
        tick();
        awvalid = 1'b0;
        check("wfirst_wait", {bvalid, awready}, 2'b00);
        check("wfirst_reg_pre", reg_q[95:64], 32'hFFFF_FFFF);
        tick();
        check("wfirst_bvalid", {bvalid, bresp}, 3'b100);
        check("wfirst_reg", reg_q[95:64], 32'hFF22_FF44);
        check("wfirst_pulse", wr_pulse, 8'h04);
        check("wfirst_ready_back", {awready, wready}, 2'b11);

        // BREADY held low: second write waits, response stays stable.
        @(negedge clk);
        bready = 1'b0;
        awaddr = 5'h04; wdata = 32'h7777_7777; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        check("bp_first_resp", {bvalid, bresp}, 3'b110);
        awaddr = 5'h0C; wdata = 32'h5555_5555; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_hold%0d_resp", k), {bvalid, bresp}, 3'b110);
            check($sformatf("bp_hold%0d_reg", k), reg_q[127:96], 32'hFFFF_0000);
            check($sformatf("bp_hold%0d_pulse", k), wr_pulse, 8'h00);
            tick();
        end
        bready = 1'b1;
        tick();
        check("bp_second_resp", {bvalid, bresp}, 3'b100);
        check("bp_second_reg", reg_q[127:96], 32'h5555_5555);
        check("bp_second_pulse", wr_pulse, 8'h08);
        tick();
        check("bp_drain", {bvalid, wr_pulse}, 9'h000);

        // Read issued on the commit edge returns the pre-write value.
        @(negedge clk);
        awaddr = 5'h00; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 5'h00; arvalid = 1'b1; rready = 1'b1;
        tick();
        arvalid = 1'b0;
        check("rw_same_rdata", rdata, 32'hA5A5_0001);
        check("rw_same_reg", reg_q[31:0], 32'hDEAD_BEEF);
        check("rw_same_valids", {rvalid, bvalid}, 2'b11);
        tick();

        // Six-register instance: upper addresses are illegal.
        @(negedge clk);
        s_araddr = 5'h1C; s_arvalid = 1'b1; s_rready = 1'b1;
        tick();
        s_arvalid = 1'b0;
        check("n6_oor_read", {s_rvalid, s_rresp, s_rdata}, {1'b1, 2'b10, 32'h0});
        check("n6_oor_rd_pulse", s_rd_pulse, 6'h00);
        tick();
        s_araddr = 5'h14; s_arvalid = 1'b1;
        tick();
        s_arvalid = 1'b0;
        check("n6_last_read", {s_rvalid, s_rresp, s_rdata}, {1'b1, 2'b00, 32'h0});
        check("n6_last_rd_pulse", s_rd_pulse, 6'h20);
        tick();
        s_awaddr = 5'h18; s_wdata = 32'h9999_9999; s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        tick();
        check("n6_oor_write", {s_bvalid, s_bresp}, 3'b110);
        check("n6_oor_wr_pulse", s_wr_pulse, 6'h00);
        check("n6_reg_q", s_reg_q, '0);

        // Reset in the middle of a stalled read.
        @(negedge clk);
        araddr = 5'h0C; arvalid = 1'b1; rready = 1'b0;
        tick();
        arvalid = 1'b0;
        check("mid_read_data", {rvalid, rdata}, {1'b1, 32'h5555_5555});
        tick();
        check("mid_read_held", {rvalid, rdata}, {1'b1, 32'h5555_5555});
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_read", {rvalid, rdata}, 33'h0);
        check("mid_rst_reg_q", reg_q, '0);
        check("mid_rst_ready", {awready, wready, arready}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1; rready = 1'b1;
        @(negedge clk);
        check("mid_rel_ready", {awready, wready, arready, rvalid}, 4'b1110);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
